// File: rtl/pixel_phase_sequencer.sv
// pixel_phase_sequencer: runtime-programmable erase -> expose -> convert -> read x N_ROWS
// sequencer with a start/busy/done handshake, single-shot or continuous framing, and abort.
// Every output is a flop; the next phase's strobe is set on the same edge the current one clears.
module pixel_phase_sequencer #(
  parameter int CNT_W  = 8,
  parameter int N_ROWS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [CNT_W-1:0]  t_erase,
  input  logic [CNT_W-1:0]  t_expose,
  input  logic [CNT_W-1:0]  t_convert,
  input  logic [CNT_W-1:0]  t_read,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [N_ROWS-1:0] read,
  output logic              busy,
  output logic              frame_done
);

  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_row;

  // The erase length is consumed on the latch edge itself, so only the later phases need a shadow copy.
  logic [CNT_W-1:0] r_tExpose;
  logic [CNT_W-1:0] r_tConvert;
  logic [CNT_W-1:0] r_tRead;

  // A programmed length of 0 behaves as 1, so the counter reload is max(t,1)-1.
  function automatic logic [CNT_W-1:0] loadVal(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  // Phase sequencing, counter, row index, shadow latching and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_row      <= '0;
      r_tExpose  <= '0;
      r_tConvert <= '0;
      r_tRead    <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start && !abort) begin
          r_tExpose  <= t_expose;
          r_tConvert <= t_convert;
          r_tRead    <= t_read;
          r_cnt      <= loadVal(t_erase);
          r_row      <= '0;
          r_state    <= ERASE;
          erase      <= 1'b1;
          busy       <= 1'b1;
        end
      end else if (abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_row   <= '0;
        erase   <= 1'b0;
        expose  <= 1'b0;
        convert <= 1'b0;
        read    <= '0;
        busy    <= 1'b0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        case (r_state)
          ERASE: begin
            r_state <= EXPOSE;
            r_cnt   <= loadVal(r_tExpose);
            erase   <= 1'b0;
            expose  <= 1'b1;
          end
          EXPOSE: begin
            r_state <= CONVERT;
            r_cnt   <= loadVal(r_tConvert);
            expose  <= 1'b0;
            convert <= 1'b1;
          end
          CONVERT: begin
            r_state <= READ;
            r_cnt   <= loadVal(r_tRead);
            r_row   <= '0;
            convert <= 1'b0;
            read    <= N_ROWS'(1);
          end
          READ: begin
            if (r_row != LAST_ROW) begin
              r_row <= r_row + ROW_W'(1);
              r_cnt <= loadVal(r_tRead);
              read  <= read << 1;
            end else begin
              frame_done <= 1'b1;
              read       <= '0;
              r_row      <= '0;
              if (continuous) begin
                r_tExpose  <= t_expose;
                r_tConvert <= t_convert;
                r_tRead    <= t_read;
                r_cnt      <= loadVal(t_erase);
                r_state    <= ERASE;
                erase      <= 1'b1;
              end else begin
                r_cnt   <= '0;
                r_state <= IDLE;
                busy    <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            erase   <= 1'b0;
            expose  <= 1'b0;
            convert <= 1'b0;
            read    <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
